bit_serial_alu: RTL and testbench

BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

---
 rtl/bit_serial_alu.sv | 135 +++++++++++++
 tb/tb_bit_serial_alu.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: AND/OR/ADD/SUB/SLT through a single 1-bit slice, LSB first, WIDTH+2 cycles per op.
// Define BIT_SERIAL_ALU_FLAGS_EN to add the registered zero and ovf outputs.
//
// state | meaning
// IDLE  | waiting for start; operands latched when start is seen
// RUN   | one bit per cycle through the slice, bit counter 0..WIDTH-1
// DONE  | one-cycle done pulse; result/cout already loaded
module bit_serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             add_sub,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef BIT_SERIAL_ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_sh;
  logic [2:0]       sel_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             bx, sum, co, bit_s, is_arith, v, cout_fin;
  logic [WIDTH-1:0] res_fin;
  logic [2:0]       sel_in;

  assign sel_in = {add_sub, op};
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice; sel_q[2] selects the inverted-B path used by SUB and SLT.
  always_comb begin
    bx       = sel_q[2] ? ~b_q[0] : b_q[0];
    sum      = a_q[0] ^ bx ^ carry;
    co       = (a_q[0] & bx) | (carry & (a_q[0] ^ bx));
    is_arith = (sel_q == OP_ADD) || (sel_q == OP_SUB);
    v        = carry ^ co;
    bit_s    = 1'b0;
    case (sel_q)
      OP_AND:                 bit_s = a_q[0] & b_q[0];
      OP_OR:                  bit_s = a_q[0] | b_q[0];
      OP_ADD, OP_SUB, OP_SLT: bit_s = sum;
      default:                bit_s = 1'b0;
    endcase
    if (sel_q == OP_SLT) res_fin = {{(WIDTH-1){1'b0}}, sum ^ v};
    else                 res_fin = {bit_s, res_sh};
    cout_fin = is_arith & co;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      res_sh <= '0;
      result <= '0;
      cout   <= 1'b0;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
      zero   <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          sel_q <= sel_in;
          cnt   <= '0;
          carry <= (sel_in == OP_ADD) ? cin : ((sel_in == OP_SUB) || (sel_in == OP_SLT));
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          carry <= co;
          cnt   <= cnt + 1'b1;
          // Outputs change only on the edge into DONE; lower bits accumulate in res_sh.
          if (cnt == LAST) begin
            result <= res_fin;
            cout   <= cout_fin;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
            zero   <= (res_fin == '0);
            ovf    <= is_arith & v;
`endif
          end else begin
            res_sh[cnt] <= bit_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed self-checking bench for bit_serial_alu (WIDTH=8); checks zero/ovf when BIT_SERIAL_ALU_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_bit_serial_alu;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0, add_sub = 1'b0;
  logic [1:0] op = '0;
  logic       busy, done, cout;
  logic [7:0] result;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
  logic       zero, ovf;
`endif

  int errors = 0;
  int checks = 0;

  bit_serial_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .add_sub(add_sub), .op(op), .busy(busy), .done(done),
    .result(result), .cout(cout)
`ifdef BIT_SERIAL_ALU_FLAGS_EN
    , .zero(zero), .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] sel, input logic [7:0] va,
                        input logic [7:0] vb, input logic vc, input logic [7:0] er,
                        input logic ec, input logic eo);
    int n;
    @(negedge clk);
    a = va; b = vb; cin = vc; {add_sub, op} = sel; start = 1'b1;
    @(posedge clk); #1;
    // scramble inputs after acceptance; the running op must not see them
    start = 1'b0; a = ~va; b = vb ^ 8'h5A; cin = ~vc; {add_sub, op} = ~sel;
    check({tag, "_busy"}, 32'(busy), 32'(1'b1));
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd8);
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef BIT_SERIAL_ALU_FLAGS_EN
    check({tag, "_zero"}, 32'(zero), 32'(er == 8'h00));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: ovf expectation unknown for %s", tag);
`endif
    @(posedge clk); #1;
    check({tag, "_done_end"}, 32'(done), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    logic [8:0] exp_s;
    int ndone;
    exp_s = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("add_7f_01",  3'b010, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_cin",    3'b010, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    run_op("sub_05_07",  3'b110, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    run_op("sub_07_05",  3'b110, 8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 1'b0);
    run_op("sub_33_33",  3'b110, 8'h33, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("slt_80_01",  3'b111, 8'h80, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
    run_op("slt_01_80",  3'b111, 8'h01, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("slt_10_10",  3'b111, 8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("and",        3'b000, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0);
    run_op("or",         3'b001, 8'hF0, 8'h3C, 1'b0, 8'hFC, 1'b0, 1'b0);
    run_op("op100",      3'b100, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
    run_op("op011",      3'b011, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b0);

    // start held high, operands changing every cycle: accept at edges 0, 10, 20
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      a = 8'(i * 7 + 3); b = 8'(i * 11 + 5); cin = 1'b0; {add_sub, op} = 3'b010; start = 1'b1;
      @(posedge clk);
      if (i % 10 == 0) exp_s = {1'b0, a} + {1'b0, b};
      #1;
      check($sformatf("tput_done_%0d", i), 32'(done), 32'(i % 10 == 8));
      if (i % 10 == 8) begin
        check($sformatf("tput_res_%0d", i), 32'(result), 32'(exp_s[7:0]));
        check($sformatf("tput_cout_%0d", i), 32'(cout), 32'(exp_s[8]));
      end
      if (done) ndone++;
    end
    @(negedge clk); start = 1'b0;
    check("tput_count", 32'(ndone), 32'd3);
    repeat (2) @(posedge clk);

    // reset after the third bit of an ADD
    @(negedge clk);
    a = 8'h55; b = 8'h0F; cin = 1'b0; {add_sub, op} = 3'b010; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_op("add_ff_01",  3'b010, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
